// File: rtl/eau_ptr_bank.sv
// Bank of NPTR address pointers, loaded lane by lane from the data bus, with post-inc/dec and a muxed address output.
// Define EAU_PTR_BANK_READBACK_EN to add the sequencer that serialises a pointer back onto the data bus.
module eau_ptr_bank #(
    parameter int DW   = 8,
    parameter int AW   = 16,
    parameter int NPTR = 4,
    localparam int NLANE = AW / DW,
    localparam int SW    = (NPTR > 1) ? $clog2(NPTR) : 1,
    localparam int LW    = (NLANE > 1) ? $clog2(NLANE) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] d_in,
    input  logic [SW-1:0] sel,
    input  logic          ld,
    input  logic [LW-1:0] lane,
    input  logic          inc,
    input  logic          dec,
    input  logic          ao,
    output logic [AW-1:0] a,
    input  logic          rd_req,
    output logic [DW-1:0] d_out,
    output logic          d_vld,
    output logic          busy
);

    logic [AW-1:0] ptr_q [NPTR];
    logic [AW-1:0] ptr_d [NPTR];
    logic          sel_ok;
    logic [AW-1:0] sel_ptr;

    assign sel_ok  = int'(sel) < NPTR;
    assign sel_ptr = sel_ok ? ptr_q[sel] : '0;
    assign a       = ao ? sel_ptr : '0;

    // NOTE: every always_comb output gets its default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        ptr_d = ptr_q;
        if (sel_ok) begin
            if (ld) begin
                if (int'(lane) < NLANE) begin
                    ptr_d[sel][int'(lane)*DW +: DW] = d_in;
                end
            end else if (inc && !dec) begin
                ptr_d[sel] = ptr_q[sel] + 1'b1;
            end else if (dec && !inc) begin
                ptr_d[sel] = ptr_q[sel] - 1'b1;
            end
        end
    end

    // NOTE: the pointer bank is a handful of flops, not a RAM, so clearing every entry on reset is cheap and required.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NPTR; i++) begin
                ptr_q[i] <= '0;
            end
        end else begin
            ptr_q <= ptr_d;
        end
    end

`ifdef EAU_PTR_BANK_READBACK_EN
    typedef enum logic {S_IDLE, S_SHIFT} state_t;

    localparam logic [LW-1:0] LAST_LANE = LW'(NLANE - 1);

    state_t        state_q, state_d;
    logic [AW-1:0] snap_q, snap_d;
    logic [LW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] d_out_q, d_out_d;

    // The snapshot is taken from ptr_q, i.e. the value before this edge's own update.
    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        cnt_d   = cnt_q;
        d_out_d = d_out_q;
        case (state_q)
            S_IDLE: begin
                d_out_d = '0;
                if (rd_req) begin
                    snap_d  = sel_ptr;
                    cnt_d   = '0;
                    d_out_d = sel_ptr[DW-1:0];
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (cnt_q == LAST_LANE) begin
                    state_d = S_IDLE;
                    d_out_d = '0;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    d_out_d = snap_q[int'(cnt_d)*DW +: DW];
                end
            end
            default: begin
                state_d = S_IDLE;
                d_out_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            snap_q  <= '0;
            cnt_q   <= '0;
            d_out_q <= '0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            cnt_q   <= cnt_d;
            d_out_q <= d_out_d;
        end
    end

    // A beat is on the bus exactly while the sequencer sits in SHIFT.
    assign d_out = d_out_q;
    assign d_vld = (state_q == S_SHIFT);
    assign busy  = (state_q == S_SHIFT);
`else
    logic rd_req_unused;

    assign rd_req_unused = rd_req;
    assign d_out         = '0;
    assign d_vld         = 1'b0;
    assign busy          = 1'b0;
`endif

endmodule

// File: tb/tb_eau_ptr_bank.sv
// Bench for eau_ptr_bank: a queue-based model checked every cycle plus directed literal expectations.
// Readback expectations follow EAU_PTR_BANK_READBACK_EN as seen at compile time.
module tb_eau_ptr_bank;

`ifdef EAU_PTR_BANK_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif
    localparam int DW = 8, AW = 16, NPTR = 4, NLANE = AW / DW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] d_in = '0;
    logic [1:0]    sel = '0;
    logic          ld = 1'b0, inc = 1'b0, dec = 1'b0, ao = 1'b0, rd_req = 1'b0;
    logic [0:0]    lane = '0;
    logic [AW-1:0] a;
    logic [DW-1:0] d_out;
    logic          d_vld, busy;

    int n_cmp = 0;
    int n_fail = 0;

    eau_ptr_bank #(.DW(DW), .AW(AW), .NPTR(NPTR)) dut (
        .clk(clk), .rst_n(rst_n), .d_in(d_in), .sel(sel), .ld(ld), .lane(lane),
        .inc(inc), .dec(dec), .ao(ao), .a(a), .rd_req(rd_req),
        .d_out(d_out), .d_vld(d_vld), .busy(busy)
    );

    always #5 clk = ~clk;

    // Model: pointer values as plain integers, readback as a queue of pending beats.
    logic [AW-1:0] m_ptr [NPTR];
    logic [DW-1:0] m_beats [$];
    logic          m_vld = 1'b0;
    logic [DW-1:0] m_dout = '0;

    initial begin
        for (int i = 0; i < NPTR; i++) m_ptr[i] = '0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                for (int i = 0; i < NPTR; i++) m_ptr[i] = '0;
                m_beats = {};
                m_vld   = 1'b0;
                m_dout  = '0;
            end else begin
                if (RB && rd_req && !m_vld) begin
                    for (int i = 0; i < NLANE; i++) m_beats.push_back(DW'(m_ptr[sel] >> (i * DW)));
                end
                if (m_beats.size() > 0) begin
                    m_dout = m_beats.pop_front();
                    m_vld  = 1'b1;
                end else begin
                    m_dout = '0;
                    m_vld  = 1'b0;
                end
                if (ld) begin
                    if (int'(lane) < NLANE)
                        m_ptr[sel] = (m_ptr[sel] & ~(AW'(8'hFF) << (lane * DW))) | (AW'(d_in) << (lane * DW));
                end else if (inc && !dec) begin
                    m_ptr[sel] = m_ptr[sel] + 16'd1;
                end else if (dec && !inc) begin
                    m_ptr[sel] = m_ptr[sel] - 16'd1;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check("cyc_a", 32'(a), 32'(ao ? m_ptr[sel] : 16'h0));
                check("cyc_d_vld", 32'(d_vld), 32'(m_vld));
                check("cyc_busy", 32'(busy), 32'(m_vld));
                check("cyc_d_out", 32'(d_out), 32'(m_dout));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Reset state
        ao = 1'b1;
        for (int s = 0; s < NPTR; s++) begin
            sel = 2'(s);
            #1;
            check("rst_a", 32'(a), 32'h0);
        end
        check("rst_d_vld", 32'(d_vld), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);

        // Lane load into pointer 2
        sel = 2'd2; ld = 1'b1; lane = 1'b0; d_in = 8'h34; cyc();
        lane = 1'b1; d_in = 8'h12; cyc();
        ld = 1'b0;
        #1 check("load_a", 32'(a), 32'h1234);
        for (int s = 0; s < NPTR; s++) begin
            if (s != 2) begin
                sel = 2'(s);
                #1 check("load_other", 32'(a), 32'h0);
            end
        end
        sel = 2'd2; ao = 1'b0;
        #1 check("ao_off", 32'(a), 32'h0);
        ao = 1'b1;

        // Inc/dec on pointer 1
        sel = 2'd1; ld = 1'b1; lane = 1'b0; d_in = 8'hFF; cyc();
        lane = 1'b1; cyc();
        ld = 1'b0;
        #1 check("ffff", 32'(a), 32'hFFFF);
        inc = 1'b1; cyc(); inc = 1'b0;
        #1 check("inc_wrap", 32'(a), 32'h0000);
        dec = 1'b1; cyc(); dec = 1'b0;
        #1 check("dec_wrap", 32'(a), 32'hFFFF);
        inc = 1'b1; dec = 1'b1; cyc(); dec = 1'b0;
        #1 check("inc_dec", 32'(a), 32'hFFFF);
        cyc(); inc = 1'b0;
        #1 check("inc_to0", 32'(a), 32'h0000);
        ld = 1'b1; lane = 1'b0; d_in = 8'h55; inc = 1'b1; cyc();
        ld = 1'b0; inc = 1'b0;
        #1 check("ld_over_inc", 32'(a), 32'h0055);

        // Readback of pointer 2 with a mid-sequence load and dropped request
        sel = 2'd2; rd_req = 1'b1; cyc();
        check("rb_beat0", 32'(d_out), RB ? 32'h34 : 32'h0);
        check("rb_vld0", 32'(d_vld), 32'(RB));
        ld = 1'b1; lane = 1'b1; d_in = 8'hAA; cyc();
        ld = 1'b0; rd_req = 1'b0;
        check("rb_beat1", 32'(d_out), RB ? 32'h12 : 32'h0);
        check("rb_busy1", 32'(busy), 32'(RB));
        cyc();
        check("rb_done_vld", 32'(d_vld), 32'h0);
        check("rb_done_busy", 32'(busy), 32'h0);
        check("rb_ptr2", 32'(a), 32'hAA34);

        // Held request with sel and pointer changes mid-sequence; spacing is covered per cycle
        for (int i = 0; i < 7; i++) begin
            rd_req = 1'b1;
            sel = (i == 1) ? 2'd1 : 2'd2;
            inc = (i == 1);
            cyc();
        end
        rd_req = 1'b0; inc = 1'b0; sel = 2'd2;
        cyc(); cyc();

        // Reset during the first beat
        rd_req = 1'b1; cyc(); rd_req = 1'b0;
        #1 check("mid_vld_pre", 32'(d_vld), 32'(RB));
        rst_n = 1'b0;
        #1;
        check("mid_vld", 32'(d_vld), 32'h0);
        check("mid_busy", 32'(busy), 32'h0);
        check("mid_d_out", 32'(d_out), 32'h0);
        check("mid_a", 32'(a), 32'h0);
        cyc();
        rst_n = 1'b1;
        for (int s = 0; s < NPTR; s++) begin
            sel = 2'(s);
            #1 check("post_rst_a", 32'(a), 32'h0);
        end
        repeat (4) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/eau_ptr_bank.md
# eau_ptr_bank

Parametrised external address unit: a bank of `NPTR` address pointers, each `AW` bits wide, loaded lane by lane from the `DW`-bit data bus. Each pointer supports post-increment and post-decrement, and one pointer at a time drives the address bus. An optional readback sequencer serialises a pointer back onto the data bus one lane per cycle. It sits between the CPU data bus and the memory address bus. It supersedes the fixed 16-bit, single-register, high/low-strobe address latch.

## Interface

Parameters:
- `DW`, default 8: data bus width.
- `AW`, default 16: pointer and address width. `AW` must be a multiple of `DW`, with `AW >= DW`.
- `NPTR`, default 4: number of pointers (at least 1).
- Derived values:
  - `NLANE = AW/DW`.
  - `SW = max(1, clog2(NPTR))`.
  - `LW = max(1, clog2(NLANE))`.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  — system clock; all state updates on the rising edge.
- `rst_n`  in  1  — asynchronous active-low reset.
- `d_in`  in  DW  — data bus input.
- `sel`  in  SW  — pointer select for load, inc/dec, address output and readback start.
- `ld`  in  1  — load `d_in` into lane `lane` of pointer `sel`.
- `lane`  in  LW  — lane index; lane 0 = bits `[DW-1:0]`.
- `inc`  in  1  — post-increment pointer `sel` by 1.
- `dec`  in  1  — post-decrement pointer `sel` by 1.
- `ao`  in  1  — address output enable.
- `a`  out  AW  — address bus.
- `rd_req`  in  1  — start readback of pointer `sel`.
- `d_out`  out  DW  — readback data.
- `d_vld`  out  1  — `d_out` holds a valid lane.
- `busy`  out  1  — readback in progress.

## Operation

- **Reset:** all pointers = 0; FSM = IDLE; `d_out` = 0, `d_vld` = 0, `busy` = 0. Reset takes effect immediately, including mid-readback; the sequence is aborted, not resumed.
- **Pointer update priority:** one update per cycle, applied to pointer `sel` only.
  - `ld` wins over `inc`/`dec`.
  - `inc` alone adds 1 modulo 2^AW; 0xFFFF → 0x0000.
  - `dec` alone subtracts 1 modulo 2^AW; 0x0000 → 0xFFFF.
  - `inc` && `dec` together leaves the pointer unchanged.
  - `lane >= NLANE` with `ld` is ignored.
- **Address output:** `a = ao ? ptr[sel] : 0`, combinational from registered state.
- **Readback FSM:** two states.
  - IDLE:
    - `rd_req` = 1 snapshots `ptr[sel]` into a shadow register.
    - Lane counter is cleared and the FSM goes to SHIFT.
    - The snapshot sees the pointer value before any same-edge update.
  - SHIFT:
    - Each cycle, present lane `cnt` of the snapshot on `d_out`, with `d_vld` = `busy` = 1.
    - After lane `NLANE-1`, return to IDLE.
  - `rd_req` while `busy` = 1 is ignored; requests are not queued.
  - Loads, inc/dec and `sel` changes during SHIFT do not alter the beats already in flight.
- When `d_vld` = 0, `d_out` = 0.

## Timing

- A pointer update sampled at edge N is visible on `a` after edge N.
- Readback with `rd_req` sampled at edge N:
  - Lane i appears on `d_out`, with `d_vld` = 1, during cycle N+1+i, for i = 0 .. NLANE-1.
  - `busy` = 1 for exactly NLANE cycles.
- `d_out`, `d_vld` and `busy` are registered; none is combinational from inputs.
- Minimum spacing between readbacks: `rd_req` is accepted at the first edge where `busy` = 0, i.e. one idle cycle after the last beat.

## Configuration

- `EAU_PTR_BANK_READBACK_EN`
  - Defined: readback FSM, snapshot register and lane counter are present, and behave as described above.
  - Undefined: none of that logic is instantiated; `rd_req` is ignored; `d_out` = 0, `d_vld` = 0 and `busy` = 0 constantly. Pointer load, inc/dec and address output are unaffected.

## Test plan

All scenarios use `DW` = 8, `AW` = 16, `NPTR` = 4 unless stated otherwise.

- **Reset:**
  - Stimulus: assert `rst_n` = 0 asynchronously, then release.
  - Required response: with `ao` = 1, `a` = 0x0000 for every `sel`; `d_vld` = 0; `busy` = 0.
- **Lane load:**
  - Stimulus: `sel` = 2; `ld` lane 0 = 0x34, then `ld` lane 1 = 0x12; `ao` = 1.
  - Required response: `a` = 0x1234; pointers 0, 1 and 3 remain 0.
  - Stimulus: `ao` = 0.
  - Required response: `a` = 0x0000.
- **Inc/dec:**
  - Pointer 1 = 0xFFFF, `inc` → 0x0000.
  - Pointer 1 = 0x0000, `dec` → 0xFFFF.
  - `inc` && `dec` → no change.
  - `ld` lane 0 = 0x55 with `inc` on pointer 1 = 0x0000 → 0x0055.
- **Readback:**
  - Stimulus: pointer 2 = 0x1234, `rd_req` at edge N.
  - Required response: cycle N+1 `d_out` = 0x34; cycle N+2 `d_out` = 0x12; `d_vld` = `busy` = 1 for exactly those two cycles.
  - Stimulus: during cycle N+1, `ld` lane 1 = 0xAA on pointer 2, plus a second `rd_req`.
  - Required response: second beat is still 0x12; the second request is dropped.
- **Reset mid-readback:**
  - Stimulus: drop `rst_n` during the first beat.
  - Required response: `d_vld`, `busy` and `d_out` go to 0 immediately; all pointers read 0 after release; no further beats.
- **Macro off:**
  - Build without `EAU_PTR_BANK_READBACK_EN`.
  - Stimulus: `rd_req` pulses.
  - Required response: `d_vld` and `busy` never assert; load/inc/dec results match the scenarios above.
